// File: rtl/ob_cn_table_mc.sv
`default_nettype none
// ============================================================================
// Module   : ob_cn_table_mc (with package ob_cn_pkg, sub-module ob_cn_table_entry)
// Purpose  : Multi-channel conditional-order table. Up to N pending
//            conditional commands are watched against the live best bid/ask.
//            Entries that have matured are forwarded, up to M per cycle,
//            into M independent valid/accept output registers.
// Revision : 1.0 - initial release
//
// Build option:
//   OB_CN_TABLE_MC_AGE_EN  defined   -> oldest-first grants (NxN age matrix)
//                          undefined -> round-robin grants (rotating pointer)
//
// Ports (ob_cn_table_mc):
//   clk, rst                 clock, synchronous active-high reset
//   cmd_vld / cmd_r          install a command (ignored while cmd_rdy = 0)
//   cmd_rdy                  table not full
//   mtr_accept[M]            per-channel consume of mtr_r[c]
//   mtr_vld_r[M] / mtr_r[M]  per-channel matured command
//   cntrl_evt_texe_r         trade-execution event, entries re-evaluate
//   lm_bid/ask_table_vld_r   best bid / ask valid
//   lm_bid/ask_table_r       best bid / ask price
//   cancel / cancel_uid      cancel request for a uid
//   cancel_hit_w             same cycle: a busy entry matched the cancel uid
//   full_r, empty_r, occ_r   registered occupancy status
//
// Maturity rule per command:
//   side = 1 : matures when bid valid and bid price >= command price
//   side = 0 : matures when ask valid and ask price <= command price
// ============================================================================

package ob_cn_pkg;
    typedef logic [7:0] uid_t;

    typedef struct packed {
        logic [15:0] price;
    } table_t;

    typedef struct packed {
        uid_t        uid;
        logic        side;
        logic [15:0] price;
        logic [15:0] qty;
    } cmd_t;
endpackage

// ============================================================================
// Module   : ob_cn_table_entry
// Purpose  : One table slot. Holds a command, evaluates its trigger on each
//            trade-execution event and latches maturity until deallocated.
// Revision : 1.0 - initial release
//
// Ports:
//   alloc_i / cmd_i   install command (slot must be free)
//   dealloc_i         release slot (granted to a channel or cancelled)
//   evt_i             trade-execution event
//   bid_*/ask_*       live best bid / ask
//   busy_o            slot holds a command
//   matured_o         slot is eligible for a grant this cycle
//   cmd_o             stored command
// ============================================================================
module ob_cn_table_entry
    import ob_cn_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   alloc_i,
    input  cmd_t   cmd_i,
    input  logic   dealloc_i,
    input  logic   evt_i,
    input  logic   bid_vld_i,
    input  table_t bid_i,
    input  logic   ask_vld_i,
    input  table_t ask_i,
    output logic   busy_o,
    output logic   matured_o,
    output cmd_t   cmd_o
);

    logic busy_q;
    logic matured_q;
    cmd_t cmd_q;
    logic trig_w;
    logic now_w;

    always_comb begin
        if (cmd_q.side) begin
            trig_w = bid_vld_i && (bid_i.price >= cmd_q.price);
        end else begin
            trig_w = ask_vld_i && (ask_i.price <= cmd_q.price);
        end
    end

    // Maturing this cycle makes the entry grantable immediately, which gives
    // the one-cycle maturity-to-output latency.
    assign now_w = busy_q & evt_i & trig_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            matured_q <= 1'b0;
            cmd_q     <= '0;
        end else if (alloc_i) begin
            busy_q    <= 1'b1;
            matured_q <= 1'b0;
            cmd_q     <= cmd_i;
        end else if (dealloc_i) begin
            busy_q    <= 1'b0;
            matured_q <= 1'b0;
        end else if (now_w) begin
            matured_q <= 1'b1;
        end
    end

    assign busy_o    = busy_q;
    assign matured_o = busy_q & (matured_q | now_w);
    assign cmd_o     = cmd_q;

endmodule

// ============================================================================
// Module   : ob_cn_table_mc  (top)
// ============================================================================
module ob_cn_table_mc
    import ob_cn_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_vld,
    input  cmd_t                   cmd_r,
    output logic                   cmd_rdy,
    input  logic [M-1:0]           mtr_accept,
    output logic [M-1:0]           mtr_vld_r,
    output cmd_t [M-1:0]           mtr_r,
    input  logic                   cntrl_evt_texe_r,
    input  logic                   lm_bid_table_vld_r,
    input  table_t                 lm_bid_table_r,
    input  logic                   lm_ask_table_vld_r,
    input  table_t                 lm_ask_table_r,
    input  logic                   cancel,
    input  uid_t                   cancel_uid,
    output logic                   cancel_hit_w,
    output logic                   full_r,
    output logic                   empty_r,
    output logic [$clog2(N+1)-1:0] occ_r
);

    localparam int OW = $clog2(N+1);
    localparam int IW = $clog2(N);

    // Entry status
    logic [N-1:0]  busy_w;
    logic [N-1:0]  mat_w;
    logic [N-1:0]  hit_w;
    cmd_t          ent_cmd_w [N];

    // Allocation
    logic          do_alloc_w;
    logic          alloc_found_w;
    logic [IW-1:0] alloc_idx_w;
    logic [N-1:0]  alloc_vec_w;

    // Grant selection
    logic [M-1:0]  mtr_free_w;
    logic [N-1:0]  pool_w;
    logic          sel_found_w;
    logic [IW-1:0] sel_idx_w;
    logic [M-1:0]  gnt_vld_w;
    logic [IW-1:0] gnt_idx_w [M];
    logic [N-1:0]  gnt_mask_w;

    // Next-state occupancy
    logic [N-1:0]  dealloc_w;
    logic [N-1:0]  busy_d;
    logic [OW-1:0] occ_d;

    // Registered outputs
    logic [M-1:0]  mtr_vld_q;
    cmd_t [M-1:0]  mtr_q;
    logic          full_q;
    logic          empty_q;
    logic [OW-1:0] occ_q;

`ifdef OB_CN_TABLE_MC_AGE_EN
    // age_q[a][b] = 1 : entry a was allocated before entry b
    logic [N-1:0]  age_q [N];
    logic          older_w;
`else
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] cand_w;
    logic          any_gnt_w;
    logic [IW-1:0] last_idx_w;
`endif

    // ------------------------------------------------------------------
    // Entries
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_entry
        ob_cn_table_entry u_entry (
            .clk       (clk),
            .rst       (rst),
            .alloc_i   (alloc_vec_w[i]),
            .cmd_i     (cmd_r),
            .dealloc_i (dealloc_w[i]),
            .evt_i     (cntrl_evt_texe_r),
            .bid_vld_i (lm_bid_table_vld_r),
            .bid_i     (lm_bid_table_r),
            .ask_vld_i (lm_ask_table_vld_r),
            .ask_i     (lm_ask_table_r),
            .busy_o    (busy_w[i]),
            .matured_o (mat_w[i]),
            .cmd_o     (ent_cmd_w[i])
        );

        // Only table entries are searched; commands already sitting in a
        // channel register cannot be cancelled.
        assign hit_w[i] = cancel & busy_w[i] & (ent_cmd_w[i].uid == cancel_uid);
    end

    assign cancel_hit_w = |hit_w;

    // ------------------------------------------------------------------
    // Allocation: lowest-index slot that is free in the current state.
    // A slot released this cycle is not reused until next cycle.
    // ------------------------------------------------------------------
    assign cmd_rdy    = ~full_q;
    assign do_alloc_w = cmd_vld & ~full_q;

    always_comb begin
        alloc_found_w = 1'b0;
        alloc_idx_w   = '0;
        alloc_vec_w   = '0;
        for (int i = 0; i < N; i++) begin
            if (!busy_w[i] && !alloc_found_w) begin
                alloc_found_w = 1'b1;
                alloc_idx_w   = IW'(i);
            end
        end
        if (do_alloc_w) begin
            alloc_vec_w[alloc_idx_w] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Grant: free channels are filled in ascending order, each removing
    // its winner from the pool before the next channel selects.
    // ------------------------------------------------------------------
    assign mtr_free_w = ~mtr_vld_q | mtr_accept;

    always_comb begin
        pool_w      = mat_w & ~hit_w;   // cancel beats maturity
        gnt_vld_w   = '0;
        gnt_mask_w  = '0;
        sel_found_w = 1'b0;
        sel_idx_w   = '0;
`ifdef OB_CN_TABLE_MC_AGE_EN
        older_w     = 1'b0;
`else
        cand_w      = '0;
        any_gnt_w   = 1'b0;
        last_idx_w  = '0;
`endif
        for (int c = 0; c < M; c++) begin
            gnt_idx_w[c] = '0;
            sel_found_w  = 1'b0;
            sel_idx_w    = '0;
`ifdef OB_CN_TABLE_MC_AGE_EN
            // Oldest pool member: no other pool member is older than it.
            for (int i = 0; i < N; i++) begin
                older_w = 1'b0;
                for (int j = 0; j < N; j++) begin
                    if (pool_w[j] && age_q[j][i]) begin
                        older_w = 1'b1;
                    end
                end
                if (pool_w[i] && !older_w && !sel_found_w) begin
                    sel_found_w = 1'b1;
                    sel_idx_w   = IW'(i);
                end
            end
`else
            // First pool member at or after the pointer, circularly.
            for (int k = 0; k < N; k++) begin
                cand_w = IW'((int'(rr_ptr_q) + k) % N);
                if (pool_w[cand_w] && !sel_found_w) begin
                    sel_found_w = 1'b1;
                    sel_idx_w   = cand_w;
                end
            end
`endif
            if (mtr_free_w[c] && sel_found_w) begin
                gnt_vld_w[c]          = 1'b1;
                gnt_idx_w[c]          = sel_idx_w;
                pool_w[sel_idx_w]     = 1'b0;
                gnt_mask_w[sel_idx_w] = 1'b1;
`ifndef OB_CN_TABLE_MC_AGE_EN
                any_gnt_w             = 1'b1;
                last_idx_w            = sel_idx_w;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy: status flags reflect the state after this cycle's
    // allocation, transfers and cancels.
    // ------------------------------------------------------------------
    assign dealloc_w = hit_w | gnt_mask_w;
    assign busy_d    = (busy_w & ~dealloc_w) | alloc_vec_w;

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < N; i++) begin
            occ_d = occ_d + OW'(busy_d[i]);
        end
    end

    // ------------------------------------------------------------------
    // Channel registers and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mtr_vld_q <= '0;
            mtr_q     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            occ_q     <= '0;
        end else begin
            for (int c = 0; c < M; c++) begin
                if (gnt_vld_w[c]) begin
                    mtr_vld_q[c] <= 1'b1;
                    mtr_q[c]     <= ent_cmd_w[gnt_idx_w[c]];
                end else if (mtr_accept[c]) begin
                    mtr_vld_q[c] <= 1'b0;
                end
            end
            full_q  <= &busy_d;
            empty_q <= ~|busy_d;
            occ_q   <= occ_d;
        end
    end

`ifdef OB_CN_TABLE_MC_AGE_EN
    // The new entry becomes younger than every other entry. Stale relations
    // with free slots are harmless: they are rewritten when that slot is
    // next allocated, and only busy entries ever compete.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                age_q[i] <= '0;
            end
        end else if (do_alloc_w) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (alloc_idx_w == IW'(i)) begin
                        age_q[i][j] <= 1'b0;
                    end else if (alloc_idx_w == IW'(j)) begin
                        age_q[i][j] <= 1'b1;
                    end
                end
            end
        end
    end
`else
    // Pointer moves just past the last entry granted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (any_gnt_w) begin
            rr_ptr_q <= (last_idx_w == IW'(N-1)) ? '0 : last_idx_w + 1'b1;
        end
    end
`endif

    assign mtr_vld_r = mtr_vld_q;
    assign mtr_r     = mtr_q;
    assign full_r    = full_q;
    assign empty_r   = empty_q;
    assign occ_r     = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_ob_cn_table_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ob_cn_table_mc
// Purpose  : Self-checking bench for ob_cn_table_mc (N=4, M=2). A queue-free
//            behavioural model of the table is checked against the DUT every
//            cycle; directed literal checks pin the model at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ob_cn_table_mc;
    import ob_cn_pkg::*;

    localparam int N = 4;
    localparam int M = 2;

    logic         clk;
    logic         rst;
    logic         cmd_vld;
    cmd_t         cmd_r;
    logic         cmd_rdy;
    logic [M-1:0] mtr_accept;
    logic [M-1:0] mtr_vld_r;
    cmd_t [M-1:0] mtr_r;
    logic         evt;
    logic         bid_vld;
    table_t       bid;
    logic         ask_vld;
    table_t       ask;
    logic         cancel;
    uid_t         cancel_uid;
    logic         cancel_hit_w;
    logic         full_r;
    logic         empty_r;
    logic [2:0]   occ_r;

    int n_cmp = 0;
    int n_bad = 0;

    ob_cn_table_mc #(.N(N), .M(M)) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_vld            (cmd_vld),
        .cmd_r              (cmd_r),
        .cmd_rdy            (cmd_rdy),
        .mtr_accept         (mtr_accept),
        .mtr_vld_r          (mtr_vld_r),
        .mtr_r              (mtr_r),
        .cntrl_evt_texe_r   (evt),
        .lm_bid_table_vld_r (bid_vld),
        .lm_bid_table_r     (bid),
        .lm_ask_table_vld_r (ask_vld),
        .lm_ask_table_r     (ask),
        .cancel             (cancel),
        .cancel_uid         (cancel_uid),
        .cancel_hit_w       (cancel_hit_w),
        .full_r             (full_r),
        .empty_r            (empty_r),
        .occ_r              (occ_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: slots hold a command, a matured flag and the
    // allocation sequence number; channels hold the forwarded command.
    // ------------------------------------------------------------------
    bit   m_busy [N];
    bit   m_mat  [N];
    cmd_t m_cmd  [N];
    int   m_seq  [N];
    int   m_ctr;
    int   m_ptr;
    bit   m_vld  [M];
    cmd_t m_mtr  [M];
    bit   m_init = 1'b0;

    function automatic bit m_trig(input cmd_t c);
        if (c.side) return bid_vld && (bid.price >= c.price);
        return ask_vld && (ask.price <= c.price);
    endfunction

    task automatic m_check();
        int occ = 0;
        bit hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_busy[i]) occ++;
            if (cancel && m_busy[i] && m_cmd[i].uid == cancel_uid) hit = 1'b1;
        end
        chk("occ_r",        64'(occ_r),        64'(occ));
        chk("full_r",       64'(full_r),       64'(occ == N));
        chk("empty_r",      64'(empty_r),      64'(occ == 0));
        chk("cmd_rdy",      64'(cmd_rdy),      64'(occ < N));
        chk("cancel_hit_w", 64'(cancel_hit_w), 64'(hit));
        for (int c = 0; c < M; c++) begin
            chk($sformatf("mtr_vld_r[%0d]", c), 64'(mtr_vld_r[c]), 64'(m_vld[c]));
            if (m_vld[c]) chk($sformatf("mtr_r[%0d]", c), 64'(mtr_r[c]), 64'(m_mtr[c]));
        end
    endtask

    task automatic m_step();
        bit hit  [N];
        bit pool [N];
        bit mnow [N];
        bit gone [N];
        int occ   = 0;
        int tgt   = -1;
        int pick;
        int last  = 0;
        bit any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_busy[i]) occ++;
            else if (tgt < 0) tgt = i;
            hit[i]  = cancel && m_busy[i] && (m_cmd[i].uid == cancel_uid);
            mnow[i] = m_busy[i] && (m_mat[i] || (evt && m_trig(m_cmd[i])));
            pool[i] = mnow[i] && !hit[i];
            gone[i] = hit[i];
        end
        for (int c = 0; c < M; c++) begin
            if (!m_vld[c] || mtr_accept[c]) begin
                pick = -1;
`ifdef OB_CN_TABLE_MC_AGE_EN
                for (int i = 0; i < N; i++)
                    if (pool[i] && (pick < 0 || m_seq[i] < m_seq[pick])) pick = i;
`else
                for (int k = 0; k < N; k++)
                    if (pick < 0 && pool[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
`endif
                if (pick >= 0) begin
                    m_mtr[c]   = m_cmd[pick];
                    m_vld[c]   = 1'b1;
                    pool[pick] = 1'b0;
                    gone[pick] = 1'b1;
                    any        = 1'b1;
                    last       = pick;
                end else begin
                    m_vld[c] = 1'b0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (gone[i]) begin
                m_busy[i] = 1'b0;
                m_mat[i]  = 1'b0;
            end else begin
                m_mat[i] = mnow[i];
            end
        end
        if (cmd_vld && occ < N) begin
            m_busy[tgt] = 1'b1;
            m_mat[tgt]  = 1'b0;
            m_cmd[tgt]  = cmd_r;
            m_seq[tgt]  = m_ctr;
            m_ctr++;
        end
        if (any) m_ptr = (last + 1) % N;
    endtask

    // Single compare process: inputs are stable between the negedge and the
    // following posedge, so the model advances here using the same inputs
    // the DUT sees at that posedge.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 1'b0;
                m_mat[i]  = 1'b0;
                m_cmd[i]  = '0;
                m_seq[i]  = 0;
            end
            for (int c = 0; c < M; c++) begin
                m_vld[c] = 1'b0;
                m_mtr[c] = '0;
            end
            m_ctr  = 0;
            m_ptr  = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            m_check();
            m_step();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        cancel  = 1'b0;
        evt     = 1'b0;
    endtask

    task automatic do_alloc(input logic [7:0] u, input logic s, input logic [15:0] p);
        cmd_vld = 1'b1;
        cmd_r   = '{uid: u, side: s, price: p, qty: {8'h00, u}};
        tick();
    endtask

    task automatic do_cancel(input logic [7:0] u);
        cancel     = 1'b1;
        cancel_uid = u;
        tick();
    endtask

    logic [7:0] exp_ord [3];

    initial begin
        rst        = 1'b1;
        cmd_vld    = 1'b0;
        cmd_r      = '0;
        mtr_accept = '0;
        evt        = 1'b0;
        bid_vld    = 1'b0;
        bid        = '0;
        ask_vld    = 1'b1;
        ask.price  = 16'd1000;
        cancel     = 1'b0;
        cancel_uid = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst mtr_vld_r", 64'(mtr_vld_r), 64'd0);
        chk("rst mtr_r",     64'(mtr_r),     64'd0);
        chk("rst occ_r",     64'(occ_r),     64'd0);
        chk("rst empty_r",   64'(empty_r),   64'd1);
        chk("rst full_r",    64'(full_r),    64'd0);
        chk("rst cmd_rdy",   64'(cmd_rdy),   64'd1);

        // Fill the table; the fifth command is dropped
        mtr_accept = 2'b11;
        do_alloc(8'h10, 1'b0, 16'd50);    // e0: sell-side? no, ask <= 50
        do_alloc(8'h11, 1'b1, 16'd100);   // e1
        do_alloc(8'h12, 1'b1, 16'd250);   // e2
        do_alloc(8'h13, 1'b1, 16'd150);   // e3
        chk("fill occ_r",   64'(occ_r),   64'd4);
        chk("fill full_r",  64'(full_r),  64'd1);
        chk("fill cmd_rdy", 64'(cmd_rdy), 64'd0);
        do_alloc(8'h14, 1'b1, 16'd0);
        chk("drop occ_r",   64'(occ_r),   64'd4);

        // Entries 1 and 3 mature together, both channels free
        bid_vld   = 1'b1;
        bid.price = 16'd200;
        evt       = 1'b1;
        tick();
        bid_vld = 1'b0;
        chk("dual mtr_vld_r", 64'(mtr_vld_r),  64'h3);
        chk("dual ch0 uid",   64'(mtr_r[0].uid), 64'h11);
        chk("dual ch1 uid",   64'(mtr_r[1].uid), 64'h13);
        chk("dual occ_r",     64'(occ_r),      64'd2);
        chk("dual full_r",    64'(full_r),     64'd0);
        tick();
        chk("drain mtr_vld_r", 64'(mtr_vld_r), 64'h0);

        // Channel 0 stalls; later maturities must use channel 1
        mtr_accept = 2'b10;
        do_alloc(8'h15, 1'b1, 16'd100);   // into e1
        do_alloc(8'h16, 1'b1, 16'd120);   // into e3
        bid_vld   = 1'b1;
        bid.price = 16'd110;
        evt       = 1'b1;
        tick();
        chk("stall ch0 load", 64'(mtr_r[0].uid), 64'h15);
        bid.price = 16'd130;
        evt       = 1'b1;
        tick();
        chk("stall ch1 vld",  64'(mtr_vld_r),  64'h3);
        chk("stall ch1 uid",  64'(mtr_r[1].uid), 64'h16);
        repeat (4) tick();
        chk("stall ch0 held", 64'(mtr_r[0].uid), 64'h15);
        chk("stall ch0 vld",  64'(mtr_vld_r),  64'h1);

        // Cancel entry 2 in the very cycle it matures
        bid.price  = 16'd260;
        evt        = 1'b1;
        cancel     = 1'b1;
        cancel_uid = 8'h12;
        #1;
        chk("mature-cancel hit", 64'(cancel_hit_w), 64'd1);
        tick();
        bid_vld = 1'b0;
        chk("mature-cancel vld", 64'(mtr_vld_r), 64'h1);
        chk("mature-cancel occ", 64'(occ_r),     64'd1);

        // Cancel of a uid that already sits in channel 0 does not hit
        cancel     = 1'b1;
        cancel_uid = 8'h15;
        #1;
        chk("chan-cancel hit", 64'(cancel_hit_w), 64'd0);
        tick();
        chk("chan-cancel vld", 64'(mtr_vld_r[0]), 64'd1);
        chk("chan-cancel uid", 64'(mtr_r[0].uid), 64'h15);
        mtr_accept = 2'b11;
        tick();
        do_cancel(8'h10);
        chk("empty after cancel", 64'(empty_r), 64'd1);

        // Build allocation order 3,0,2 with entry 1 parked on the ask side
        do_alloc(8'h20, 1'b1, 16'd100);
        do_alloc(8'h21, 1'b0, 16'd10);
        do_alloc(8'h22, 1'b1, 16'd100);
        do_alloc(8'h23, 1'b1, 16'd100);
        do_cancel(8'h23);
        do_alloc(8'h30, 1'b1, 16'd100);   // e3
        do_cancel(8'h20);
        do_alloc(8'h31, 1'b1, 16'd100);   // e0
        do_cancel(8'h22);
        do_alloc(8'h32, 1'b1, 16'd100);   // e2
        chk("order occ_r", 64'(occ_r), 64'd4);

        // Park entry 1 in a stalled channel 0 so channel 1 behaves as M=1
        mtr_accept = 2'b10;
        ask.price  = 16'd5;
        evt        = 1'b1;
        tick();
        ask.price = 16'd1000;
        chk("park ch0 uid", 64'(mtr_r[0].uid), 64'h21);

`ifdef OB_CN_TABLE_MC_AGE_EN
        exp_ord = '{8'h30, 8'h31, 8'h32};   // entries 3,0,2: oldest first
`else
        exp_ord = '{8'h32, 8'h30, 8'h31};   // entries 2,3,0: pointer sits at 2 after entry 1
`endif
        bid_vld   = 1'b1;
        bid.price = 16'd150;
        evt       = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("order ch1 #%0d", k), 64'(mtr_r[1].uid), 64'(exp_ord[k]));
        end
        bid_vld = 1'b0;
        chk("order occ_r end", 64'(occ_r), 64'd0);

        // Reset in mid-operation: channel 0 holds a command, one entry busy
        do_alloc(8'h40, 1'b1, 16'd500);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-rst mtr_vld_r", 64'(mtr_vld_r), 64'd0);
        chk("mid-rst mtr_r",     64'(mtr_r),     64'd0);
        chk("mid-rst occ_r",     64'(occ_r),     64'd0);
        chk("mid-rst empty_r",   64'(empty_r),   64'd1);
        chk("mid-rst cmd_rdy",   64'(cmd_rdy),   64'd1);
        mtr_accept = 2'b11;
        do_alloc(8'h41, 1'b1, 16'd500);
        chk("post-rst occ_r", 64'(occ_r), 64'd1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
